// File: rtl/trap_ctrl.sv
// Trap controller: classifies retiring instructions, saves trap CSRs,
// issues fetch redirects and latches the simulation-end halt status.
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_instr,
  output logic        commit_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        halt,
  output logic [1:0]  halt_code,
  output logic [31:0] halt_pc,
  output logic [31:0] trap_count
);

  typedef enum logic [1:0] {IDLE, SAVE, REDIRECT, HALTED} state_t;
  typedef enum logic [2:0] {K_NONE, K_EBREAK, K_ECALL, K_MRET, K_ILLEGAL} kind_t;

  localparam logic [11:0] A_MTVEC  = 12'h305;
  localparam logic [11:0] A_MEPC   = 12'h341;
  localparam logic [11:0] A_MCAUSE = 12'h342;
  localparam logic [11:0] A_MTVAL  = 12'h343;

  state_t      state;
  kind_t       kind;
  logic        legal_op;
  logic        accept;
  logic        hw_owns;
  logic [31:0] csr_wdata_al;
  logic [31:0] mtvec, mepc, mcause, mtval;
  logic [31:0] save_pc, save_cause, save_tval;

  assign commit_ready = (state == IDLE) && !rst;
  assign accept       = commit_valid && commit_ready;
  assign hw_owns      = (state == SAVE);
  assign csr_wdata_al = {csr_wdata[31:2], 2'b00};

  always_comb begin
    case (commit_instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0010011, 7'b0110011, 7'b0100011, 7'b0001111,
      7'b1110011, 7'b0000011, 7'b1100011: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  always_comb begin
    kind = K_NONE;
    if (commit_instr == 32'h00100073)      kind = K_EBREAK;
    else if (commit_instr == 32'h00000073) kind = K_ECALL;
    else if (commit_instr == 32'h30200073) kind = K_MRET;
    else if (!legal_op)                    kind = K_ILLEGAL;
  end

  always_comb begin
    case (csr_addr)
      A_MTVEC:  csr_rdata = mtvec;
      A_MEPC:   csr_rdata = mepc;
      A_MCAUSE: csr_rdata = mcause;
      A_MTVAL:  csr_rdata = mtval;
      default:  csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      mtvec          <= RESET_MTVEC;
      mepc           <= '0;
      mcause         <= '0;
      mtval          <= '0;
      trap_count     <= '0;
      halt           <= 1'b0;
      halt_code      <= 2'b00;
      halt_pc        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      save_pc        <= '0;
      save_cause     <= '0;
      save_tval      <= '0;
    end else begin
      // Software writes to registers the SAVE cycle updates are dropped.
      if (csr_we && state != HALTED) begin
        case (csr_addr)
          A_MTVEC:  mtvec <= csr_wdata_al;
          A_MEPC:   if (!hw_owns) mepc <= csr_wdata_al;
          A_MCAUSE: if (!hw_owns) mcause <= csr_wdata;
          A_MTVAL:  if (!hw_owns) mtval <= csr_wdata;
          default:  ;
        endcase
      end
      case (state)
        IDLE: begin
          if (accept) begin
            case (kind)
              K_EBREAK: begin
                halt      <= 1'b1;
                halt_code <= 2'b01;
                halt_pc   <= commit_pc;
                state     <= HALTED;
              end
              K_ECALL: begin
                save_pc    <= commit_pc;
                save_cause <= 32'd11;
                save_tval  <= '0;
                state      <= SAVE;
              end
              K_MRET: begin
                redirect_pc    <= mepc;
                redirect_valid <= 1'b1;
                state          <= REDIRECT;
              end
              K_ILLEGAL: begin
                if (mtvec != '0) begin
                  save_pc    <= commit_pc;
                  save_cause <= 32'd2;
                  save_tval  <= commit_instr;
                  state      <= SAVE;
                end else begin
                  halt      <= 1'b1;
                  halt_code <= 2'b10;
                  halt_pc   <= commit_pc;
                  state     <= HALTED;
                end
              end
              default: ;
            endcase
          end
        end
        SAVE: begin
          mepc           <= save_pc;
          mcause         <= save_cause;
          mtval          <= save_tval;
          trap_count     <= trap_count + 32'd1;
          redirect_pc    <= {mtvec[31:2], 2'b00};
          redirect_valid <= 1'b1;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h00000000, the reset value of mtvec.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port commit_valid  input  1  the core presents a retiring instruction.
REQ-005 SHALL have port commit_pc  input  32  PC of the presented instruction.
REQ-006 SHALL have port commit_instr  input  32  encoding of the presented instruction.
REQ-007 SHALL have port commit_ready  output  1  this block accepts the presented instruction.
REQ-008 SHALL have port redirect_valid  output  1  a fetch redirect is pending.
REQ-009 SHALL have port redirect_pc  output  32  redirect target.
REQ-010 SHALL have port redirect_ready  input  1  fetch consumes the redirect.
REQ-011 SHALL have port csr_we  input  1  software CSR write strobe.
REQ-012 SHALL have port csr_addr  input  12  CSR address: 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval.
REQ-013 SHALL have port csr_wdata  input  32  CSR write data.
REQ-014 SHALL have port csr_rdata  output  32  combinational read of csr_addr; 0 for unmapped addresses.
REQ-015 SHALL have port halt  output  1  sticky simulation-end flag.
REQ-016 SHALL have port halt_code  output  2  2'b01 good (ebreak), 2'b10 bad (illegal, no handler).
REQ-017 SHALL have port halt_pc  output  32  PC of the halting instruction.
REQ-018 SHALL have port trap_count  output  32  number of vectored trap entries.

Function
REQ-019 SHALL implement FSM states IDLE, SAVE, REDIRECT, HALTED.
REQ-020 SHALL drive commit_ready=1 only in IDLE with rst low; a handshake is commit_valid&commit_ready.
REQ-021 SHALL classify each accepted instruction in its handshake cycle, using the mtvec value from the start of that cycle:
  - ebreak 32'h00100073 -> HALTED, with halt_code=01 and halt_pc=commit_pc
  - ecall 32'h00000073 -> SAVE with cause 11, tval 0
  - mret 32'h30200073 -> REDIRECT with target mepc
  - illegal -> SAVE with cause 2, tval=commit_instr, when mtvec!=0; else HALTED with halt_code=10
  - all other instructions -> stay in IDLE, no action
REQ-022 SHALL treat as illegal any opcode[6:0] outside {0110111, 0010111, 1101111, 1100111, 0010011, 0110011, 0100011, 0001111, 1110011, 0000011, 1100011}.
REQ-023 SHALL in SAVE, lasting exactly one cycle:
  - write mepc=commit_pc captured at acceptance, with mcause and mtval
  - increment trap_count
  - set target={mtvec[31:2],2'b00}
  - go to REDIRECT
REQ-024 SHALL in REDIRECT assert redirect_valid with redirect_pc stable until redirect_valid&redirect_ready, then return to IDLE in the next cycle.
REQ-025 SHALL keep redirect_valid=0 in IDLE, SAVE and HALTED.
REQ-026 SHALL let trap_count wrap from 32'hFFFFFFFF to 0.
REQ-027 SHALL apply csr_we writes in any non-HALTED state, effective next cycle; mtvec and mepc writes store data with bits [1:0] forced to 0.
REQ-028 SHALL, when a csr_we write and a SAVE hardware write target the same register in the same cycle, keep the hardware value and drop the csr write.
REQ-029 SHALL remain in HALTED until rst, ignoring commit and CSR writes, with commit_ready=0.
REQ-030 SHALL, when commit_valid is high and commit_ready low, not capture the instruction; a held instruction is accepted exactly once.
REQ-031 SHALL set the halt fields in the cycle after the handshake, and never change halt_code once it is set.

Reset
REQ-032 SHALL, on rst high at a clock edge, regardless of state (including mid-REDIRECT), enter IDLE and reset as follows:
  - mtvec=RESET_MTVEC
  - mepc, mcause, mtval and trap_count = 0
  - halt=0, halt_code=00, halt_pc=0
  - redirect_valid=0, redirect_pc=0
REQ-033 SHALL hold commit_ready=0 during every cycle in which rst is high.

Verification
REQ-034 SHALL cover: ecall at pc 0x80000010 with mtvec=0x80000103 -> one SAVE cycle; then redirect_pc=0x80000100, mepc=0x80000010, mcause=11, trap_count=1.
REQ-035 SHALL cover: instr 0x0000007F at 0x80000020 with mtvec=0 -> halt=1, halt_code=10, halt_pc=0x80000020, commit_ready stays 0.
REQ-036 SHALL cover: 0x00100073 at 0x80000140 -> halt=1, halt_code=01; a later illegal instr leaves halt_code=01.
REQ-037 SHALL cover: mret after a trap with redirect_ready held low 3 cycles -> redirect_valid held 4 cycles at mepc, then IDLE.
REQ-038 SHALL cover: csr_we to mcause (0x342, data 5) in the SAVE cycle of an illegal trap -> mcause=2.
REQ-039 SHALL cover: rst asserted mid-REDIRECT with trap_count=0xFFFFFFFF -> next cycle IDLE, all outputs 0; a separate run wraps trap_count to 0 after one more trap.
